// File: rtl/traffic_light_seq_if.sv
// traffic_light_seq_if: demand/preempt inputs and lamp/status outputs of the sequencer
interface traffic_light_seq_if #(
  parameter int N_WAY = 4,
  parameter int IDX_W = $clog2(N_WAY)
);
  logic [N_WAY-1:0] demand;
  logic             skip_en;
  logic             preempt;
  logic [IDX_W-1:0] preempt_way;
  logic [N_WAY-1:0] grn;
  logic [N_WAY-1:0] ylw;
  logic [N_WAY-1:0] rd;
  logic [IDX_W-1:0] phase;
  logic [1:0]       state;
  modport master (
    output demand, skip_en, preempt, preempt_way,
    input  grn, ylw, rd, phase, state
  );
  modport slave (
    input  demand, skip_en, preempt, preempt_way,
    output grn, ylw, rd, phase, state
  );
endinterface

// File: rtl/traffic_light_seq.sv
// traffic_light_seq: self-timed N-approach traffic-light sequencer with demand skipping and preemption
module traffic_light_seq #(
  parameter int N_WAY    = 4,
  parameter int IDX_W    = $clog2(N_WAY),
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 20,
  parameter int YELLOW_T = 4,
  parameter int ALLRED_T = 2
) (
  input logic              clk,
  input logic              reset,
  traffic_light_seq_if.slave bus
);
  typedef enum logic [1:0] {ALLRED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10} state_e;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [N_WAY-1:0] grn_q, grn_d, ylw_q, ylw_d, rd_q, rd_d;
  logic [IDX_W-1:0] inc_way, dmd_way, nxt_way, w;
  logic             pv, expired;
  assign pv      = bus.preempt && (int'(bus.preempt_way) < N_WAY);
  assign expired = (timer_q == '0);
  // next approach: valid preemption wins, else first demanding approach after the current one, else round-robin
  always_comb begin
    w       = '0;
    inc_way = (phase_q == IDX_W'(N_WAY - 1)) ? '0 : phase_q + 1'b1;
    dmd_way = inc_way;
    for (int k = N_WAY; k >= 1; k--) begin
      w = IDX_W'((int'(phase_q) + k) % N_WAY);
      dmd_way = bus.demand[w] ? w : dmd_way;
    end
    nxt_way = pv ? bus.preempt_way : (bus.skip_en ? dmd_way : inc_way);
  end
  // phase sequencing, timer reloads and lamp decode of the next state
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    timer_d = timer_q - 1'b1;
    unique case (state_q)
      ALLRED: if (expired) begin
        state_d = GREEN;
        phase_d = nxt_way;
        timer_d = CNT_W'(GREEN_T - 1);
      end
      GREEN: if (pv && bus.preempt_way != phase_q) begin
        state_d = YELLOW;
        timer_d = CNT_W'(YELLOW_T - 1);
      end else if (pv) begin
        timer_d = CNT_W'(GREEN_T - 1);
      end else if (expired) begin
        state_d = YELLOW;
        timer_d = CNT_W'(YELLOW_T - 1);
      end
      YELLOW: if (expired) begin
        state_d = ALLRED;
        timer_d = CNT_W'(ALLRED_T - 1);
      end
      default: begin
        state_d = ALLRED;
        timer_d = CNT_W'(ALLRED_T - 1);
      end
    endcase
    grn_d = (state_d == GREEN)  ? N_WAY'(1) << phase_d : '0;
    ylw_d = (state_d == YELLOW) ? N_WAY'(1) << phase_d : '0;
    rd_d  = ~(grn_d | ylw_d);
  end
  // state, timer and registered lamp outputs; reset restarts from all-red before approach 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ALLRED;
      phase_q <= IDX_W'(N_WAY - 1);
      timer_q <= CNT_W'(ALLRED_T - 1);
      grn_q   <= '0;
      ylw_q   <= '0;
      rd_q    <= '1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      timer_q <= timer_d;
      grn_q   <= grn_d;
      ylw_q   <= ylw_d;
      rd_q    <= rd_d;
    end
  end
  assign bus.grn   = grn_q;
  assign bus.ylw   = ylw_q;
  assign bus.rd    = rd_q;
  assign bus.phase = phase_q;
  assign bus.state = state_q;
endmodule
